vreg_file: RTL

Parametrised multi-lane register file for the datapath's packed (SIMD) operand path, replacing the fixed 5-lane/16-bit file. It provides N_REG registers of LANES×DATA_W bits with two combinational read ports, one lane-masked write port and optional write-to-read bypass. A per-register busy scoreboard supports multi-cycle producers such as the multiplier. A sequential clear engine zeroes the whole file without a reset.

---
 rtl/vreg_pkg.sv | 29 ++
 rtl/vreg_scoreboard.sv | 54 +++++
 rtl/vreg_file.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vreg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vreg_pkg
//  Description : Shared definitions for the multi-lane vector register file:
//                default geometry, sweep FSM encoding and lane slice helper.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package vreg_pkg;

  // Default geometry, matching the legacy fixed 5-lane / 16-bit file
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANES  = 5;
  localparam int DEF_N_REG  = 32;
  localparam int DEF_BYPASS = 1;

  // Clear-sweep controller states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

  // Low bit index of lane 'lane' inside a packed word of 'width'-bit lanes
  function automatic int unsigned lane_lo(input int unsigned lane,
                                          input int unsigned width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vreg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : vreg_scoreboard
//  Description : One busy bit per register. Set by an issued producer,
//                cleared by the write that retires it, flushed wholesale when
//                a clear sweep starts. Two combinational lookup ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module vreg_scoreboard
  import vreg_pkg::*;
#(
  parameter int N_REG = DEF_N_REG,
  localparam int AW   = $clog2(N_REG)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          flush,
  input  logic [AW-1:0] look_addr_1,
  input  logic [AW-1:0] look_addr_2,
  output logic          busy_1,
  output logic          busy_2
);

  logic [N_REG-1:0] busy_q;

  // Busy bits: flush beats everything; set is ordered after clear so that a
  // simultaneous set and clear on one register leaves it busy.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      if (clr_en) begin
        busy_q[clr_addr] <= 1'b0;
      end
      if (set_en && (set_addr != '0)) begin
        busy_q[set_addr] <= 1'b1;
      end
    end
  end

  // Lookup ports; register 0 can never have been set, so it reads idle
  always_comb begin
    busy_1 = busy_q[look_addr_1];
    busy_2 = busy_q[look_addr_2];
  end

endmodule
`default_nettype wire

// File: rtl/vreg_file.sv
`default_nettype none
// ============================================================================
//  Module      : vreg_file
//  Description : Parametrised multi-lane register file. N_REG words of
//                LANES x DATA_W bits, two combinational read ports, one
//                lane-masked write port, optional write-to-read bypass,
//                busy scoreboard and a sequential clear sweep.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module vreg_file
  import vreg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int N_REG  = DEF_N_REG,
  parameter int BYPASS = DEF_BYPASS,
  localparam int AW    = $clog2(N_REG)
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    reg_write,
  input  logic [AW-1:0]           waddr,
  input  logic [LANES-1:0]        wmask,
  input  logic [LANES*DATA_W-1:0] wdata,
  input  logic [AW-1:0]           raddr_1,
  input  logic [AW-1:0]           raddr_2,
  output logic [LANES*DATA_W-1:0] rdata_1,
  output logic [LANES*DATA_W-1:0] rdata_2,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_addr,
  output logic                    busy_1,
  output logic                    busy_2,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int            W         = LANES * DATA_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_REG - 1);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

  sweep_state_t  state;
  sweep_state_t  state_nxt;
  logic [AW-1:0] sweep_cnt;
  logic          sweep_wr;
  logic          sweep_start;

  logic [W-1:0]  regs [N_REG];
  logic [W-1:0]  lane_bits;
  logic [W-1:0]  wr_merged;
  logic          wr_acc;

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------

  // Expand the per-lane mask to a per-bit mask
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_mask
      assign lane_bits[lane_lo(i, DATA_W) +: DATA_W] = {DATA_W{wmask[i]}};
    end
  endgenerate

  // Accepted write: never to register 0, never while sweeping. The merged
  // word is the old contents with the masked lanes replaced.
  always_comb begin
    wr_acc    = reg_write && !clr_busy && (waddr != '0);
    wr_merged = (regs[waddr] & ~lane_bits) | (wdata & lane_bits);
  end

  // Storage array: sweep zeroing and normal writes are mutually exclusive
  // because writes are only accepted outside the sweep.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int r = 0; r < N_REG; r++) begin
        regs[r] <= '0;
      end
    end else if (sweep_wr) begin
      regs[sweep_cnt] <= '0;
    end else if (wr_acc) begin
      regs[waddr] <= wr_merged;
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  generate
    if (BYPASS != 0) begin : g_bypass
      logic hit_1;
      logic hit_2;
      // Forward the merged word when the read hits the accepted write; the
      // merge already keeps unmasked lanes from the array.
      always_comb begin
        hit_1   = wr_acc && (waddr == raddr_1);
        hit_2   = wr_acc && (waddr == raddr_2);
        rdata_1 = hit_1 ? wr_merged : regs[raddr_1];
        rdata_2 = hit_2 ? wr_merged : regs[raddr_2];
      end
    end else begin : g_no_bypass
      // Plain array reads
      always_comb begin
        rdata_1 = regs[raddr_1];
        rdata_2 = regs[raddr_2];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Clear sweep FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave SWEEP on the edge that zeroes the last register
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_req) state_nxt = ST_SWEEP;
      ST_SWEEP: if (sweep_cnt == LAST_ADDR) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    clr_busy    = (state == ST_SWEEP);
    sweep_wr    = (state == ST_SWEEP);
    sweep_start = (state == ST_IDLE) && clr_req;
  end

  // Sweep address counter: loaded to 1 on entry (register 0 needs no
  // clearing), returns to 0 once the last register has been zeroed.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sweep_cnt <= '0;
    end else if (sweep_start) begin
      sweep_cnt <= FIRST_ADDR;
    end else if (sweep_wr) begin
      sweep_cnt <= (sweep_cnt == LAST_ADDR) ? '0 : sweep_cnt + AW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Busy scoreboard: issues are dropped while sweeping, the sweep entry
  // edge flushes every bit.
  // --------------------------------------------------------------------------
  vreg_scoreboard #(
    .N_REG (N_REG)
  ) u_scoreboard (
    .clk         (clk),
    .arst_n      (arst_n),
    .set_en      (issue_valid && !clr_busy),
    .set_addr    (issue_addr),
    .clr_en      (wr_acc),
    .clr_addr    (waddr),
    .flush       (sweep_start),
    .look_addr_1 (raddr_1),
    .look_addr_2 (raddr_2),
    .busy_1      (busy_1),
    .busy_2      (busy_2)
  );

endmodule
`default_nettype wire
